// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: start-bit validation, N data bits LSB first, optional parity, 1..2 stop bits.
// Define UART_RX_SYNC_EN to pass i_rx through a 2-flop synchronizer (+2 clk latency).
module uart_rx_os #(
    parameter int NB_DATA_BITS = 8,
    parameter int PARITY_MODE  = 0,
    parameter int NB_STOP_BITS = 1,
    parameter int OVERSAMPLE   = 16
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic                    i_rx,
    input  logic                    i_s_tick,
    output logic [NB_DATA_BITS-1:0] o_data,
    output logic                    o_valid,
    output logic                    o_parity_err,
    output logic                    o_frame_err,
    output logic                    o_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_DATA = 4'(NB_DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(NB_STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync;

    // Synchronizer resets to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) rx_sync <= 2'b11;
        else          rx_sync <= {rx_sync[0], i_rx};
    end
    assign rx_s = rx_sync[1];
`else
    assign rx_s = i_rx;
`endif

    state_t                  state, state_n;
    logic [TW-1:0]           tick_cnt, tick_n;
    logic [3:0]              bit_cnt, bit_n;
    logic [NB_DATA_BITS-1:0] shreg, shreg_n;
    logic                    par_err, par_err_n;
    logic                    stop_err, stop_err_n;
    logic [NB_DATA_BITS-1:0] data_n;
    logic                    valid_n, perr_n, ferr_n;

    // NOTE: every next-value gets a default first, so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_n    = state;
        tick_n     = tick_cnt;
        bit_n      = bit_cnt;
        shreg_n    = shreg;
        par_err_n  = par_err;
        stop_err_n = stop_err;
        data_n     = o_data;
        valid_n    = 1'b0;
        perr_n     = o_parity_err;
        ferr_n     = o_frame_err;

        case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n    = S_START;
                    tick_n     = '0;
                    bit_n      = '0;
                    par_err_n  = 1'b0;
                    stop_err_n = 1'b0;
                end
            end
            S_START: begin
                if (i_s_tick) begin
                    if (tick_cnt == HALF_M1) begin
                        tick_n  = '0;
                        state_n = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (i_s_tick) begin
                    if (tick_cnt == FULL_M1) begin
                        tick_n  = '0;
                        shreg_n = {rx_s, shreg[NB_DATA_BITS-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_n   = '0;
                            state_n = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_n = bit_cnt + 4'd1;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (i_s_tick) begin
                    if (tick_cnt == FULL_M1) begin
                        tick_n    = '0;
                        // Even parity fails on an odd count of ones; odd parity on an even count.
                        par_err_n = (PARITY_MODE == 1) ? (^shreg ^ rx_s) : ~(^shreg ^ rx_s);
                        state_n   = S_STOP;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (i_s_tick) begin
                    if (tick_cnt == FULL_M1) begin
                        tick_n = '0;
                        if (bit_cnt == LAST_STOP) begin
                            bit_n   = '0;
                            state_n = S_IDLE;
                            valid_n = 1'b1;
                            data_n  = shreg;
                            perr_n  = (PARITY_MODE != 0) && par_err;
                            ferr_n  = stop_err | ~rx_s;
                        end else begin
                            bit_n      = bit_cnt + 4'd1;
                            stop_err_n = stop_err | ~rx_s;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            // NOTE: the shift register is a plain register, not a memory, so it is cheap to clear on reset.
            shreg        <= '0;
            par_err      <= 1'b0;
            stop_err     <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            state        <= state_n;
            tick_cnt     <= tick_n;
            bit_cnt      <= bit_n;
            shreg        <= shreg_n;
            par_err      <= par_err_n;
            stop_err     <= stop_err_n;
            o_data       <= data_n;
            o_valid      <= valid_n;
            o_parity_err <= perr_n;
            o_frame_err  <= ferr_n;
        end
    end

    assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: four configurations (8N1, 8E1, 8N2, 7O1) driven by
// directed and randomized frames, compared against a frame-level reference model.
module tb_uart_rx_os;

    localparam int OS       = 16;
    localparam int TICK_DIV = 2;
    localparam int BIT_CLKS = OS * TICK_DIV;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } frame_t;

    frame_t exp_q[$];
    frame_t got_q[$];

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       s_tick = 1'b0;
    logic [3:0] rx_line = 4'hF;
    logic [7:0] d0, d1, d2;
    logic [6:0] d3;
    logic [3:0] v, pe, fe, bz;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_os #(.NB_DATA_BITS(8), .PARITY_MODE(0), .NB_STOP_BITS(1), .OVERSAMPLE(OS)) u_8n1 (
        .clk(clk), .i_rst_n(rst_n), .i_rx(rx_line[0]), .i_s_tick(s_tick),
        .o_data(d0), .o_valid(v[0]), .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_busy(bz[0]));
    uart_rx_os #(.NB_DATA_BITS(8), .PARITY_MODE(1), .NB_STOP_BITS(1), .OVERSAMPLE(OS)) u_8e1 (
        .clk(clk), .i_rst_n(rst_n), .i_rx(rx_line[1]), .i_s_tick(s_tick),
        .o_data(d1), .o_valid(v[1]), .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_busy(bz[1]));
    uart_rx_os #(.NB_DATA_BITS(8), .PARITY_MODE(0), .NB_STOP_BITS(2), .OVERSAMPLE(OS)) u_8n2 (
        .clk(clk), .i_rst_n(rst_n), .i_rx(rx_line[2]), .i_s_tick(s_tick),
        .o_data(d2), .o_valid(v[2]), .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_busy(bz[2]));
    uart_rx_os #(.NB_DATA_BITS(7), .PARITY_MODE(2), .NB_STOP_BITS(1), .OVERSAMPLE(OS)) u_7o1 (
        .clk(clk), .i_rst_n(rst_n), .i_rx(rx_line[3]), .i_s_tick(s_tick),
        .o_data(d3), .o_valid(v[3]), .o_parity_err(pe[3]), .o_frame_err(fe[3]), .o_busy(bz[3]));

    initial forever #5 clk = ~clk;

    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            c++;
            s_tick = (c % TICK_DIV == 0);
        end
    end

    function automatic int cfg_nb(input int i);
        return (i == 3) ? 7 : 8;
    endfunction

    function automatic int cfg_par(input int i);
        return (i == 1) ? 1 : (i == 3) ? 2 : 0;
    endfunction

    function automatic int cfg_stop(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic frame_t mk(input int i, input logic [8:0] d, input logic p, input logic f);
        frame_t r;
        r.inst = i;
        r.data = d;
        r.perr = p;
        r.ferr = f;
        return r;
    endfunction

    // Reference: what a frame with these line bits must report, from the framing rules alone.
    function automatic frame_t model(input int i, input logic [8:0] data, input logic pbit,
                                     input logic [1:0] stops);
        logic [8:0] word;
        int         ones;
        logic       perr;
        logic       ferr;
        word = data & 9'((1 << cfg_nb(i)) - 1);
        ones = $countones(word) + int'(pbit);
        case (cfg_par(i))
            1:       perr = (ones % 2) != 0;
            2:       perr = (ones % 2) == 0;
            default: perr = 1'b0;
        endcase
        ferr = !stops[0] || (cfg_stop(i) == 2 && !stops[1]);
        return mk(i, word, perr, ferr);
    endfunction

    // Each observed o_valid clk becomes one captured frame, so a stretched pulse shows up as an extra frame.
    always @(negedge clk) begin
        if (v[0]) got_q.push_back(mk(0, {1'b0, d0}, pe[0], fe[0]));
        if (v[1]) got_q.push_back(mk(1, {1'b0, d1}, pe[1], fe[1]));
        if (v[2]) got_q.push_back(mk(2, {1'b0, d2}, pe[2], fe[2]));
        if (v[3]) got_q.push_back(mk(3, {2'b0, d3}, pe[3], fe[3]));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input int i, input logic b, input int clks);
        rx_line[i] = b;
        repeat (clks) @(negedge clk);
    endtask

    // A low stop bit is released at 3/4 bit and followed by one idle bit, so the receiver's
    // re-trigger on the still-low line resolves cleanly as a false start.
    task automatic send_frame(input int i, input logic [8:0] data, input logic pbit,
                              input logic [1:0] stops);
        logic any_low;
        any_low = 1'b0;
        drive_bit(i, 1'b0, BIT_CLKS);
        for (int k = 0; k < cfg_nb(i); k++) drive_bit(i, data[k], BIT_CLKS);
        if (cfg_par(i) != 0) drive_bit(i, pbit, BIT_CLKS);
        for (int s = 0; s < cfg_stop(i); s++) begin
            if (stops[s]) begin
                drive_bit(i, 1'b1, BIT_CLKS);
            end else begin
                any_low = 1'b1;
                drive_bit(i, 1'b0, BIT_CLKS * 3 / 4);
                drive_bit(i, 1'b1, BIT_CLKS / 4);
            end
        end
        rx_line[i] = 1'b1;
        exp_q.push_back(model(i, data, pbit, stops));
        if (any_low) repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic compare_frames(input string tag);
        frame_t g;
        frame_t e;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check({tag, ".count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, ".inst"}, g.inst, e.inst);
            check({tag, ".data"}, {23'b0, g.data}, {23'b0, e.data});
            check({tag, ".perr"}, {31'b0, g.perr}, {31'b0, e.perr});
            check({tag, ".ferr"}, {31'b0, g.ferr}, {31'b0, e.ferr});
        end
        got_q.delete();
        exp_q.delete();
        check({tag, ".busy"}, {28'b0, bz}, 32'h0);
    endtask

    initial begin
        logic [8:0] rd;
        logic       rp;
        logic [1:0] rs;
        int         idx;

        repeat (5) @(negedge clk);
        check("reset.valid", {28'b0, v}, 32'h0);
        check("reset.busy", {28'b0, bz}, 32'h0);
        check("reset.perr", {28'b0, pe}, 32'h0);
        check("reset.ferr", {28'b0, fe}, 32'h0);
        check("reset.data", {1'b0, d3, d2, d1, d0}, 32'h0);
        rst_n = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);

        send_frame(0, 9'h0A5, 1'b0, 2'b11);
        compare_frames("8n1_a5");

        send_frame(1, 9'h007, 1'b0, 2'b11);
        send_frame(1, 9'h007, 1'b1, 2'b11);
        compare_frames("8e1_07");

        send_frame(2, 9'h03C, 1'b0, 2'b01);
        compare_frames("8n2_3c_stop2_low");

        send_frame(3, 9'h05B, 1'b0, 2'b11);
        send_frame(3, 9'h05B, 1'b1, 2'b11);
        compare_frames("7o1_5b");

        // False start: line low for 4 ticks only.
        drive_bit(0, 1'b0, 4 * TICK_DIV);
        rx_line[0] = 1'b1;
        repeat (2) @(negedge clk);
        check("false_start.busy_mid", {31'b0, bz[0]}, 32'h1);
        compare_frames("false_start");

        // Reset in the middle of data bit 3 of 0xFF, then a clean 0x12.
        drive_bit(0, 1'b0, BIT_CLKS);
        for (int k = 0; k < 3; k++) drive_bit(0, 1'b1, BIT_CLKS);
        drive_bit(0, 1'b1, BIT_CLKS / 2);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset.busy", {31'b0, bz[0]}, 32'h0);
        check("midreset.data", {24'b0, d0}, 32'h0);
        rst_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_frame(0, 9'h012, 1'b0, 2'b11);
        compare_frames("midreset_12");

        send_frame(0, 9'h055, 1'b0, 2'b11);
        send_frame(0, 9'h0AA, 1'b0, 2'b11);
        compare_frames("b2b_55_aa");

        for (int r = 0; r < 48; r++) begin
            idx = $urandom_range(0, 3);
            rd  = 9'($urandom);
            rp  = 1'($urandom);
            rs  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            send_frame(idx, rd, rp, rs);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            if (r % 8 == 7) compare_frames("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter NB_DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter PARITY_MODE, default 0, 0 = none, 1 = even, 2 = odd.
REQ-003 SHALL have parameter NB_STOP_BITS, default 1, stop bits per frame, legal 1..2.
REQ-004 SHALL have parameter OVERSAMPLE, default 16, i_s_tick pulses per bit, even, legal 8..32.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_rx  input  1  serial line, idle high.
REQ-008 SHALL have port i_s_tick  input  1  oversample tick, one-clk pulse, OVERSAMPLE per bit period.
REQ-009 SHALL have port o_data  output  NB_DATA_BITS  last received word, LSB = first data bit.
REQ-010 SHALL have port o_valid  output  1  one-clk pulse: o_data and error flags updated.
REQ-011 SHALL have port o_parity_err  output  1  parity mismatch on the last frame.
REQ-012 SHALL have port o_frame_err  output  1  a stop bit sampled low on the last frame.
REQ-013 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; the FSM advances only on i_s_tick, except the IDLE->START transition.
REQ-015 IDLE: i_rx low on any clk SHALL move the FSM to START and clear the tick counter.
REQ-016 START: after OVERSAMPLE/2 ticks (mid-bit), i_rx sampled high SHALL return the FSM to IDLE with no o_valid (false start); sampled low SHALL enter DATA with the counter cleared.
REQ-017 DATA: each bit SHALL be sampled every OVERSAMPLE ticks and shifted in LSB first; after NB_DATA_BITS samples the FSM SHALL enter PARITY if PARITY_MODE!=0, else STOP.
REQ-018 PARITY: after OVERSAMPLE ticks, sample i_rx; error = XOR(data, parity bit) != 0 for even, == 0 for odd.
REQ-019 STOP: each of NB_STOP_BITS SHALL be sampled after OVERSAMPLE ticks; any low sample sets the frame error.
REQ-020 On the last stop-bit sample the block SHALL load o_data, o_parity_err and o_frame_err, pulse o_valid for exactly one clk, and return to IDLE in the same cycle, so a start bit is detectable in the next clk.
REQ-021 o_data and both error flags SHALL hold their values until the next o_valid; no handshake back-pressure; a frame not read before the next o_valid is overwritten.
REQ-022 With PARITY_MODE=0, o_parity_err SHALL be constant 0.
REQ-023 A frame ending in a framing error SHALL still present its data bits on o_data.
REQ-024 The tick counter SHALL be ceil(log2(OVERSAMPLE)) bits wide; the bit counter SHALL be 4 bits wide; both wrap only via an explicit clear.

Reset
REQ-025 While i_rst_n is low, the FSM SHALL be IDLE, all counters and the shift register SHALL be 0, and o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_busy=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no o_valid; after release the block SHALL wait in IDLE for the next falling edge.

Configuration
REQ-027 When macro UART_RX_SYNC_EN is defined, i_rx SHALL pass through a 2-flop synchronizer reset to 1, and all detection and sampling SHALL use the synchronized signal (+2 clk latency).
REQ-028 When UART_RX_SYNC_EN is undefined, i_rx SHALL be used directly; cycle timing is 2 clk earlier and otherwise identical.

Verification
REQ-029 8N1, OVERSAMPLE=16, send 0xA5 -> exactly one o_valid pulse, o_data=0xA5, both errors 0, o_busy low after the pulse.
REQ-030 PARITY_MODE=1, send 0x07 with parity bit 0 -> o_valid, o_data=0x07, o_parity_err=1; same word with parity bit 1 -> o_parity_err=0.
REQ-031 8N2, send 0x3C with the second stop bit 0 -> o_valid, o_data=0x3C, o_frame_err=1.
REQ-032 i_rx low for 4 ticks, then high -> FSM returns to IDLE, no o_valid, o_busy low again.
REQ-033 Assert i_rst_n low during data bit 3 of 0xFF, release, send 0x12 -> no o_valid for the aborted frame, then one o_valid with o_data=0x12.
REQ-034 Back-to-back frames 0x55 and 0xAA with one stop bit and no idle gap -> two o_valid pulses, o_data=0x55 then 0xAA, no errors.
